// File: rtl/prog_mem_loader_if.sv
// ============================================================================
// Module   : prog_mem_loader_if
// Brief    : CPU fetch port and byte-stream loader port of the program memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface prog_mem_loader_if;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_data;
    logic       cpu_n_reset;
    logic       load_start;
    logic [4:0] load_len;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic       done;
    logic       err;

    // master: CPU plus host link; slave: the loader that owns the memory
    modport master (
        output cpu_addr, load_start, load_len, wr_valid, wr_data,
        input  cpu_data, cpu_n_reset, wr_ready, busy, done, err
    );

    modport slave (
        input  cpu_addr, load_start, load_len, wr_valid, wr_data,
        output cpu_data, cpu_n_reset, wr_ready, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/prog_mem_loader.sv
// ============================================================================
// Module   : prog_mem_loader
// Brief    : 16x8 program memory shared by CPU fetch and a byte-stream loader;
//            holds the CPU in reset while a program loads. Optional trailing
//            checksum byte enabled by macro PROG_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prog_mem_loader #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    prog_mem_loader_if.slave  bus
);

    localparam logic [3:0] C_HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [4:0] C_MAX_LEN   = 5'd16;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [3:0]       hold_cnt_q;
    logic [3:0]       idx_q;
    logic [4:0]       len_q;
    logic [7:0]       sum_q;
    logic             cpu_n_reset_q;
    logic             wr_ready_q;
    logic             done_q;

    logic             w_xfer;
    logic             w_last_byte;
    logic [4:0]       w_len_clamped;

    assign w_xfer      = bus.wr_valid & wr_ready_q;
    assign w_last_byte = ({1'b0, idx_q} == (len_q - 5'd1));

    // A zero or oversize length loads the whole memory
    always_comb begin
        w_len_clamped = bus.load_len;
        if (bus.load_len == 5'd0 || bus.load_len > C_MAX_LEN) begin
            w_len_clamped = C_MAX_LEN;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                end else if (hold_cnt_q == C_HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_xfer && w_last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_HOLD;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_xfer) begin
                    state_d = (bus.wr_data == sum_q) ? ST_HOLD : ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                end
            end
`endif
            default: state_d = ST_HOLD;
        endcase
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q       <= ST_HOLD;
            hold_cnt_q    <= 4'd0;
            idx_q         <= 4'd0;
            len_q         <= 5'd0;
            sum_q         <= 8'd0;
            cpu_n_reset_q <= 1'b0;
            wr_ready_q    <= 1'b0;
            done_q        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cpu_n_reset_q <= (state_d == ST_RUN);
            wr_ready_q    <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
            done_q        <= 1'b0;
            hold_cnt_q    <= (state_q == ST_HOLD && state_d == ST_HOLD) ?
                             hold_cnt_q + 4'd1 : 4'd0;

            if (state_d == ST_LOAD && state_q != ST_LOAD) begin
                len_q <= w_len_clamped;
                idx_q <= 4'd0;
                sum_q <= 8'd0;
            end

            if (state_q == ST_LOAD && w_xfer) begin
                mem_q[idx_q] <= bus.wr_data;
                idx_q        <= idx_q + 4'd1;
                sum_q        <= sum_q + bus.wr_data;
`ifndef PROG_LOADER_CHECKSUM_EN
                if (w_last_byte) begin
                    done_q <= 1'b1;
                end
`endif
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            // Checksum byte is compared only, never stored
            if (state_q == ST_CHECK && w_xfer) begin
                if (bus.wr_data == sum_q) begin
                    done_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == ST_ERROR && bus.load_start) begin
                err_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.cpu_data    = mem_q[bus.cpu_addr];
    assign bus.cpu_n_reset = cpu_n_reset_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q == ST_HOLD) || (state_q == ST_LOAD) ||
                             (state_q == ST_CHECK);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
// ============================================================================
// Module   : tb_prog_mem_loader
// Brief    : Scoreboard bench for prog_mem_loader (directed loads, reset, checksum).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_prog_mem_loader;

    localparam int SEL_DATA = 0;
    localparam int SEL_NRST = 1;
    localparam int SEL_RDY  = 2;
    localparam int SEL_BUSY = 3;
    localparam int SEL_ERR  = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    prog_mem_loader_if bus ();

    prog_mem_loader #(
        .DEPTH       (16),
        .WIDTH       (8),
        .HOLD_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    string      name_q [$];
    int         sel_q  [$];
    logic [7:0] exp_q  [$];
    int         done_q [$];

    logic [7:0] stim  [16];
    logic [7:0] model [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations pushed at a negedge, plus every done pulse
    always @(negedge clk) begin
        string      nm;
        int         s;
        logic [7:0] e;
        logic [7:0] a;
        int         ec;
        #1;
        while (sel_q.size() > 0) begin
            nm = name_q.pop_front();
            s  = sel_q.pop_front();
            e  = exp_q.pop_front();
            case (s)
                SEL_DATA: a = bus.cpu_data;
                SEL_NRST: a = {7'd0, bus.cpu_n_reset};
                SEL_RDY:  a = {7'd0, bus.wr_ready};
                SEL_BUSY: a = {7'd0, bus.busy};
                default:  a = {7'd0, bus.err};
            endcase
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
            end
        end
        if (bus.done === 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
            end else begin
                ec = done_q.pop_front();
                if (ec != cyc) begin
                    n_bad++;
                    $display("FAIL done_timing: got cycle %0d expected cycle %0d", cyc, ec);
                end
            end
        end
    end

    task automatic chk_sig(input string nm, input int sel, input logic [7:0] e);
        name_q.push_back(nm);
        sel_q.push_back(sel);
        exp_q.push_back(e);
    endtask

    task automatic chk_mem(input string nm, input logic [3:0] addr, input logic [7:0] e);
        bus.cpu_addr = addr;
        chk_sig($sformatf("%s[%0d]", nm, addr), SEL_DATA, e);
        @(negedge clk);
    endtask

    task automatic chk_all_mem(input string nm);
        for (int i = 0; i < 16; i++) begin
            chk_mem(nm, 4'(i), model[i]);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        logic rdy;
        int   guard;
        guard        = 0;
        acc_cyc      = -1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        while (acc_cyc < 0) begin
            rdy = bus.wr_ready;
            @(negedge clk);
            if (rdy) begin
                acc_cyc = cyc;
            end else begin
                guard++;
                if (guard > 50) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL send_timeout: got no wr_ready for byte %h expected acceptance", b);
                    acc_cyc = 0;
                end
            end
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_run(input string nm);
        int guard;
        guard = 0;
        while (bus.cpu_n_reset !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (bus.cpu_n_reset !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_release: got cpu_n_reset %b expected 1 within 20 cycles", nm, bus.cpu_n_reset);
        end
    endtask

    task automatic do_reset();
        bus.wr_valid   = 1'b0;
        bus.load_start = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
    endtask

    // Full load of n bytes from stim[]; poke_at >= 0 pulses load_start before that byte
    task automatic do_load(input string nm, input logic [4:0] len_in, input int n,
                           input bit toggle, input int poke_at, input bit bad_sum);
        logic [7:0] sum;
        int         acc;
        sum            = 8'h00;
        bus.load_len   = len_in;
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        chk_sig({nm, "_enter_nrst"}, SEL_NRST, 8'd0);
        chk_sig({nm, "_enter_rdy"},  SEL_RDY,  8'd1);
        chk_sig({nm, "_enter_err"},  SEL_ERR,  8'd0);
        for (int i = 0; i < n; i++) begin
            if (i == poke_at) begin
                bus.load_len   = 5'd1;
                bus.load_start = 1'b1;
                @(negedge clk);
                bus.load_start = 1'b0;
            end
            send_byte(stim[i], acc);
            model[i] = stim[i];
            sum      = sum + stim[i];
            if (toggle && i < n - 1) @(negedge clk);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(bad_sum ? 8'(sum + 8'd1) : sum, acc);
`endif
        if (!bad_sum) done_q.push_back(acc);
    endtask

    initial begin
        int acc;
        n_cmp          = 0;
        n_bad          = 0;
        bus.cpu_addr   = 4'd0;
        bus.load_start = 1'b0;
        bus.load_len   = 5'd0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = 8'h00;

        // T1: reset state, hold release after two cycles, cleared memory
        do_reset();
        chk_sig("t1_nrst0", SEL_NRST, 8'd0);
        chk_sig("t1_busy",  SEL_BUSY, 8'd1);
        chk_sig("t1_rdy",   SEL_RDY,  8'd0);
        chk_sig("t1_err",   SEL_ERR,  8'd0);
        @(negedge clk);
        chk_sig("t1_nrst1", SEL_NRST, 8'd0);
        @(negedge clk);
        chk_sig("t1_nrst2", SEL_NRST, 8'd1);
        chk_sig("t1_idle",  SEL_BUSY, 8'd0);
        chk_all_mem("t1_mem");

        // T2: three-byte load, release HOLD_CYCLES after completion
        stim[0] = 8'h31; stim[1] = 8'h01; stim[2] = 8'hF0;
        do_load("t2", 5'd3, 3, 1'b0, -1, 1'b0);
        chk_sig("t2_rdy_drop", SEL_RDY,  8'd0);
        chk_sig("t2_hold0",    SEL_NRST, 8'd0);
        @(negedge clk);
        chk_sig("t2_hold1",    SEL_NRST, 8'd0);
        @(negedge clk);
        chk_sig("t2_release",  SEL_NRST, 8'd1);
        for (int i = 0; i < 4; i++) chk_mem("t2_mem", 4'(i), model[i]);

        // T3: length 0 means 16, wr_valid toggling, stray valid afterwards
        for (int i = 0; i < 16; i++) stim[i] = {4'(i), ~4'(i)};
        do_load("t3", 5'd0, 16, 1'b1, -1, 1'b0);
        chk_sig("t3_rdy_drop", SEL_RDY, 8'd0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        repeat (3) @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_run("t3");
        chk_all_mem("t3_mem");

        // T3b: oversize length clamps to 16
        for (int i = 0; i < 16; i++) stim[i] = 8'(i * 7 + 3);
        do_load("t3b", 5'd31, 16, 1'b0, -1, 1'b0);
        chk_sig("t3b_rdy_drop", SEL_RDY, 8'd0);
        wait_run("t3b");
        chk_mem("t3b_mem", 4'd0,  8'h03);
        chk_mem("t3b_mem", 4'd15, 8'h6C);

        // T4: reset after 2 of 4 bytes discards everything, no done
        bus.load_len   = 5'd4;
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        send_byte(8'hAA, acc);
        send_byte(8'hBB, acc);
        do_reset();
        chk_sig("t4_nrst", SEL_NRST, 8'd0);
        chk_sig("t4_busy", SEL_BUSY, 8'd1);
        chk_sig("t4_rdy",  SEL_RDY,  8'd0);
        chk_all_mem("t4_mem");
        wait_run("t4");

        // T5: load_start during LOAD is ignored
        stim[0] = 8'hA5; stim[1] = 8'h3C; stim[2] = 8'h0F;
        do_load("t5", 5'd3, 3, 1'b0, 1, 1'b0);
        chk_sig("t5_rdy_drop", SEL_RDY, 8'd0);
        wait_run("t5");
        for (int i = 0; i < 4; i++) chk_mem("t5_mem", 4'(i), model[i]);

`ifdef PROG_LOADER_CHECKSUM_EN
        // T6: good checksum, then bad checksum, then recovery
        stim[0] = 8'h10; stim[1] = 8'h20;
        do_load("t6a", 5'd2, 2, 1'b0, -1, 1'b0);
        chk_sig("t6a_err", SEL_ERR, 8'd0);
        wait_run("t6a");
        chk_mem("t6a_mem", 4'd2, 8'h0F);
        do_load("t6b", 5'd2, 2, 1'b0, -1, 1'b1);
        chk_sig("t6b_err",  SEL_ERR,  8'd1);
        chk_sig("t6b_busy", SEL_BUSY, 8'd0);
        chk_sig("t6b_rdy",  SEL_RDY,  8'd0);
        repeat (4) @(negedge clk);
        chk_sig("t6b_nrst", SEL_NRST, 8'd0);
        chk_sig("t6b_err2", SEL_ERR,  8'd1);
        stim[0] = 8'h44; stim[1] = 8'h55;
        do_load("t6c", 5'd2, 2, 1'b0, -1, 1'b0);
        wait_run("t6c");
        chk_mem("t6c_mem", 4'd1, 8'h55);
`endif

        repeat (4) @(negedge clk);
        while (done_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_done: got no pulse expected one at cycle %0d", done_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
